controlador_divisor: RTL and testbench

Programmable clock-enable scheduler for the toy automation timing chain. A single shared prescaler (divide by PRESCALE) feeds N_CANAIS independent channel counters. Each channel emits a one-cycle tick and a toggling square wave (T flip-flop style) at its own programmed ratio. Divisor updates arrive over a valid/ready handshake and take effect only at the target channel's period boundary, so downstream logic never sees a truncated period.

---
 rtl/controlador_divisor_pkg.sv | 13 +
 rtl/controlador_divisor_if.sv | 15 +
 rtl/canal_divisor.sv | 54 +++++
 rtl/controlador_divisor.sv | 96 +++++++++
 tb/tb_controlador_divisor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/controlador_divisor_pkg.sv
// Shared types and constants for the clock-enable scheduler.
// Holds the configuration FSM encoding, the channel-index width and the "disabled" divisor value.
package controlador_divisor_pkg;

    typedef enum logic {
        LIVRE    = 1'b0,
        PENDENTE = 1'b1
    } estado_t;

    localparam int LARG_CANAL    = 2;
    localparam int DIV_DESLIGADO = 0;

endpackage

// File: rtl/controlador_divisor_if.sv
// Configuration handshake bundle: the requester drives valid/canal/div and the scheduler answers ready.
interface controlador_divisor_if #(
    parameter int LARG_DIV = 8
);
    import controlador_divisor_pkg::*;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [LARG_CANAL-1:0] cfg_canal;
    logic [LARG_DIV-1:0]   cfg_div;

    modport master (output cfg_valid, cfg_canal, cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, cfg_canal, cfg_div, output cfg_ready);

endinterface

// File: rtl/canal_divisor.sv
// One output channel: divides the shared base tick by its own divisor and emits a tick pulse and square wave.
// fronteira_o marks the edge on which a new divisor may be loaded without truncating a period.
module canal_divisor
    import controlador_divisor_pkg::*;
#(
    parameter int LARG_DIV = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                base_tick_i,
    input  logic                aplicar_i,
    input  logic [LARG_DIV-1:0] novo_div_i,
    output logic                tick_o,
    output logic                onda_o,
    output logic                fronteira_o
);

    logic [LARG_DIV-1:0] div_q;
    logic [LARG_DIV-1:0] cnt_q;
    logic                tick_q;
    logic                onda_q;
    logic                ligado;
    logic                wrap;

    assign ligado      = (div_q != LARG_DIV'(DIV_DESLIGADO));
    assign wrap        = base_tick_i && ligado && (cnt_q == div_q - LARG_DIV'(1));
    // A disabled channel has no period, so any base tick is a safe place to load it.
    assign fronteira_o = wrap || (base_tick_i && !ligado);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            onda_q <= 1'b0;
        end else begin
            tick_q <= wrap;
            if (wrap)
                onda_q <= ~onda_q;
            if (aplicar_i) begin
                div_q <= novo_div_i;
                cnt_q <= '0;
            end else if (wrap) begin
                cnt_q <= '0;
            end else if (base_tick_i && ligado) begin
                cnt_q <= cnt_q + LARG_DIV'(1);
            end
        end
    end

    assign tick_o = tick_q;
    assign onda_o = onda_q;

endmodule

// File: rtl/controlador_divisor.sv
// Shared prescaler feeding N_CANAIS channel dividers, plus the configuration FSM that
// defers each divisor write to the target channel's period boundary.
module controlador_divisor
    import controlador_divisor_pkg::*;
#(
    parameter int PRESCALE = 5,
    parameter int N_CANAIS = 3,
    parameter int LARG_DIV = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    controlador_divisor_if.slave  cfg_if,
    output logic [N_CANAIS-1:0]   tick_o,
    output logic [N_CANAIS-1:0]   onda_o,
    output logic                  ocupado_o
);

    localparam int LARG_PRE = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [LARG_PRE-1:0]   pre_q;
    logic                  base_tick;

    estado_t               estado_q, estado_d;
    logic [LARG_CANAL-1:0] canal_q, canal_d;
    logic [LARG_DIV-1:0]   div_q, div_d;
    logic [N_CANAIS-1:0]   aplicar;
    logic [N_CANAIS-1:0]   fronteira;
    logic                  canal_valido;

    assign base_tick = enable_i && (pre_q == LARG_PRE'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre_q <= '0;
        else if (enable_i)
            pre_q <= base_tick ? '0 : pre_q + LARG_PRE'(1);
    end

    // Out-of-range channel indices are consumed and dropped without leaving LIVRE.
    assign canal_valido = ({1'b0, cfg_if.cfg_canal} < (LARG_CANAL + 1)'(N_CANAIS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= LIVRE;
            canal_q  <= '0;
            div_q    <= '0;
        end else begin
            estado_q <= estado_d;
            canal_q  <= canal_d;
            div_q    <= div_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        canal_d  = canal_q;
        div_d    = div_q;
        aplicar  = '0;
        case (estado_q)
            LIVRE: begin
                if (cfg_if.cfg_valid && canal_valido) begin
                    estado_d = PENDENTE;
                    canal_d  = cfg_if.cfg_canal;
                    div_d    = cfg_if.cfg_div;
                end
            end
            PENDENTE: begin
                for (int i = 0; i < N_CANAIS; i++) begin
                    if (canal_q == LARG_CANAL'(i) && fronteira[i]) begin
                        aplicar[i] = 1'b1;
                        estado_d   = LIVRE;
                    end
                end
            end
            default: estado_d = LIVRE;
        endcase
    end

    assign cfg_if.cfg_ready = (estado_q == LIVRE);
    assign ocupado_o        = (estado_q == PENDENTE);

    canal_divisor #(
        .LARG_DIV (LARG_DIV)
    ) u_canal [N_CANAIS-1:0] (
        .clk         (clk),
        .reset       (reset),
        .base_tick_i (base_tick),
        .aplicar_i   (aplicar),
        .novo_div_i  (div_q),
        .tick_o      (tick_o),
        .onda_o      (onda_o),
        .fronteira_o (fronteira)
    );

endmodule

// File: tb/tb_controlador_divisor.sv
// Randomized bench: a base-tick-index reference model schedules expected ticks into per-channel
// queues; a negedge monitor pops them and compares tick, onda and handshake outputs.
module tb_controlador_divisor;

    localparam int P  = 5;
    localparam int N  = 3;
    localparam int LD = 8;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  tick_o;
    logic [N-1:0]  onda_o;
    logic          ocupado_o;

    controlador_divisor_if #(.LARG_DIV(LD)) cfg_if ();

    controlador_divisor #(
        .PRESCALE (P),
        .N_CANAIS (N),
        .LARG_DIV (LD)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .enable_i  (enable),
        .cfg_if    (cfg_if),
        .tick_o    (tick_o),
        .onda_o    (onda_o),
        .ocupado_o (ocupado_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: time measured in enabled cycles and base-tick indices.
    int          cyc   = 0;
    int          pre   = 0;
    int          nbt   = 0;
    int          m_d   [N];
    int          m_nb  [N];
    logic [N-1:0] onda_m = '0;
    logic        m_pend = 1'b0;
    int          m_pc  = 0;
    int          m_pd  = 0;
    int          exp_q [N][$];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_d[i]  = 0;
            m_nb[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pre    = 0;
                nbt    = 0;
                onda_m = '0;
                m_pend = 1'b0;
                for (int i = 0; i < N; i++) begin
                    m_d[i]  = 0;
                    m_nb[i] = 0;
                    exp_q[i].delete();
                end
            end else begin
                logic bt, old_pend;
                logic [N-1:0] hit;
                cyc++;
                old_pend = m_pend;
                bt  = enable && (pre == P - 1);
                hit = '0;
                if (enable)
                    pre = (pre + 1) % P;
                if (bt) begin
                    nbt++;
                    for (int i = 0; i < N; i++) begin
                        if (m_d[i] != 0 && nbt == m_nb[i]) begin
                            hit[i]    = 1'b1;
                            onda_m[i] = ~onda_m[i];
                            exp_q[i].push_back(cyc);
                            m_nb[i]   = nbt + m_d[i];
                        end
                    end
                    if (old_pend && (m_d[m_pc] == 0 || hit[m_pc])) begin
                        m_d[m_pc]  = m_pd;
                        m_nb[m_pc] = nbt + m_pd;
                        m_pend     = 1'b0;
                    end
                end
                if (!old_pend && cfg_if.cfg_valid && int'(cfg_if.cfg_canal) < N) begin
                    m_pend = 1'b1;
                    m_pc   = int'(cfg_if.cfg_canal);
                    m_pd   = int'(cfg_if.cfg_div);
                end
            end
        end
    end

    // Monitor: outputs are registered, so sample half a cycle after the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!m_pend));
            chk("ocupado", 32'(ocupado_o), 32'(m_pend));
            chk("onda", 32'(onda_o), 32'(onda_m));
            for (int i = 0; i < N; i++) begin
                logic e;
                e = 1'b0;
                if (exp_q[i].size() > 0 && exp_q[i][0] <= cyc) begin
                    if (exp_q[i][0] < cyc)
                        chk($sformatf("tick%0d_late", i), 32'(exp_q[i][0]), 32'(cyc));
                    void'(exp_q[i].pop_front());
                    e = 1'b1;
                end
                chk($sformatf("tick%0d", i), 32'(tick_o[i]), 32'(e));
            end
        end
    end

    task automatic cfg(input logic [1:0] c, input logic [LD-1:0] dv);
        int t = 0;
        while (m_pend && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (m_pend) begin
            total++;
            bad++;
            $display("FAIL cfg_wait t=%0t got=pending exp=idle", $time);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_canal = c;
        cfg_if.cfg_div   = dv;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_canal = 2'($urandom_range(0, 3));
        cfg_if.cfg_div   = LD'($urandom);
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_canal = '0;
        cfg_if.cfg_div   = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        cfg(0, 1);
        repeat (30) @(negedge clk);
        cfg(1, 5);
        cfg(2, 2);
        repeat (120) @(negedge clk);
        cfg(1, 3);
        repeat (100) @(negedge clk);
        cfg(3, 77);
        repeat (10) @(negedge clk);
        cfg(0, 0);
        repeat (40) @(negedge clk);
        repeat (13) @(negedge clk);
        enable = 1'b0;
        repeat (7) @(negedge clk);
        enable = 1'b1;
        repeat (60) @(negedge clk);

        for (int k = 0; k < 25; k++) begin
            logic [1:0]    c;
            logic [LD-1:0] dv;
            c  = 2'($urandom_range(0, 3));
            dv = ($urandom_range(0, 4) == 0) ? '0 : LD'($urandom_range(1, 6));
            cfg(c, dv);
            repeat ($urandom_range(5, 40)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 9)) @(negedge clk);
                enable = 1'b1;
            end
        end

        // Load ch2 with a long period, then queue a change that cannot land before reset hits.
        cfg(2, 10);
        cfg(2, 3);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tick", 32'(tick_o), 32'd0);
        chk("rst_onda", 32'(onda_o), 32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("rst_ocupado", 32'(ocupado_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
